// File: rtl/weighted_pool_selector.sv
// weighted_pool_selector
//   Keeps a pool of N_SLOT candidate records {id, size, iq, eq}. The first
//   N_SLOT accepted records fill the pool in slot order. After that, every
//   accepted record scores the current pool with its own weights:
//     score = size*w_size + iq*w_iq + eq*w_eq
//   The block picks the best slot: the maximum score when mode=0, or the
//   minimum score when mode=1. When scores tie, the lowest index wins.
//   It pushes {winner index, winner id} into a show-ahead output FIFO, and
//   the incoming record then replaces the winner slot.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous clear of the pool state and the FIFO
//   in_valid/in_ready   record handshake; in_ready is combinational
//   in_id, in_size, in_iq, in_eq            record fields
//   in_w_size, in_w_iq, in_w_eq, mode       weights and mode, used on accept only
//   out_valid/out_ready FIFO head handshake
//   out_data            {slot index, id}; reads 0 when the FIFO is empty
//   fifo_level          FIFO occupancy
module weighted_pool_selector #(
  parameter int N_SLOT     = 5,
  parameter int ID_W       = 5,
  parameter int ATTR_W     = 8,
  parameter int WT_W       = 3,
  parameter int FIFO_DEPTH = 16,
  localparam int IDX_W     = $clog2(N_SLOT),
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W-1:0]         in_id,
  input  logic [ATTR_W-1:0]       in_size,
  input  logic [ATTR_W-1:0]       in_iq,
  input  logic [ATTR_W-1:0]       in_eq,
  input  logic [WT_W-1:0]         in_w_size,
  input  logic [WT_W-1:0]         in_w_iq,
  input  logic [WT_W-1:0]         in_w_eq,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W+ID_W-1:0]   out_data,
  output logic [LVL_W-1:0]        fifo_level
);

  localparam int SC_W  = ATTR_W + WT_W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OUT_W = IDX_W + ID_W;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q;
  logic [IDX_W-1:0]  fill_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;

  logic [ID_W-1:0]   slot_id   [N_SLOT];
  logic [ATTR_W-1:0] slot_size [N_SLOT];
  logic [ATTR_W-1:0] slot_iq   [N_SLOT];
  logic [ATTR_W-1:0] slot_eq   [N_SLOT];
  logic [OUT_W-1:0]  fifo_mem  [FIFO_DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SC_W-1:0]   score [N_SLOT];
  logic [SC_W-1:0]   win_score;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  wr_slot;

  function automatic logic [SC_W-1:0] weigh(input logic [ATTR_W-1:0] a,
                                            input logic [WT_W-1:0]   w);
    return SC_W'(a) * SC_W'(w);
  endfunction

  // Scoring: each slot is weighted by the incoming record's weights
  always_comb begin
    for (int i = 0; i < N_SLOT; i++) begin
      score[i] = weigh(slot_size[i], in_w_size) + weigh(slot_iq[i], in_w_iq)
               + weigh(slot_eq[i], in_w_eq);
    end
  end

  // Selection: only a strictly better score moves the winner, so ties stay on the lower index
  always_comb begin
    win_idx   = '0;
    win_score = score[0];
    for (int i = 1; i < N_SLOT; i++) begin
      if (mode ? (score[i] < win_score) : (score[i] > win_score)) begin
        win_idx   = IDX_W'(i);
        win_score = score[i];
      end
    end
  end

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // A pop in the same cycle does not free a slot for a push into a full FIFO
  assign in_ready = !rst && !flush && ((state_q == ST_FILL) || !fifo_full);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (state_q == ST_RUN);
  assign pop      = out_valid && out_ready && !rst && !flush;
  assign wr_slot  = (state_q == ST_FILL) ? fill_cnt_q : win_idx;

  // Control registers: pool phase and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      if (accept && (state_q == ST_FILL)) begin
        if (fill_cnt_q == IDX_W'(N_SLOT - 1)) begin
          state_q    <= ST_RUN;
          fill_cnt_q <= '0;
        end else begin
          fill_cnt_q <= fill_cnt_q + IDX_W'(1);
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Data registers: pool slots and FIFO storage (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_id[wr_slot]   <= in_id;
      slot_size[wr_slot] <= in_size;
      slot_iq[wr_slot]   <= in_iq;
      slot_eq[wr_slot]   <= in_eq;
    end
    if (push) fifo_mem[wr_ptr_q] <= {win_idx, slot_id[win_idx]};
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign fifo_level = level_q;

endmodule

// File: doc/weighted_pool_selector.md
Name: weighted_pool_selector

Overview:
- Single-clock, parametrised successor to the dual-clock doraemon selector.
- Holds a pool of N_SLOT candidate records {id, size, iq, eq}.
- Once the pool is full, each accepted record triggers selection of the best-scoring slot (max or min mode). The selected {slot index, id} is pushed into an internal output FIFO, and the incoming record overwrites the selected slot.
- Sits between the record source and the result consumer, with ready/valid on both sides plus a flush.

Parameters:
N_SLOT, 5, number of pool slots (2..16)
ID_W, 5, record id width
ATTR_W, 8, width of each attribute (size, iq, eq)
WT_W, 3, width of each weight
FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)
IDX_W, $clog2(N_SLOT), slot index width (derived, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous pool and FIFO clear, active-high
in_valid  in  1  input record valid
in_ready  out  1  block can accept a record this cycle
in_id  in  ID_W  record id
in_size  in  ATTR_W  size attribute
in_iq  in  ATTR_W  iq attribute
in_eq  in  ATTR_W  eq attribute
in_w_size  in  WT_W  size weight
in_w_iq  in  WT_W  iq weight
in_w_eq  in  WT_W  eq weight
mode  in  1  0 = select max score, 1 = select min score
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops head when out_valid & out_ready
out_data  out  IDX_W+ID_W  {slot index, id} of selected record; index in MSBs
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Accept: a record is accepted when in_valid & in_ready. Weights and mode are sampled only with an accepted record.
- Reset (rst=1 at a clock edge), applied from any state:
  - state goes to FILL; fill counter = 0; FIFO emptied.
  - out_valid = 0, out_data = 0, fifo_level = 0.
  - Slot contents are don't-care.
- in_ready is combinational:
  - 0 while rst or flush is high.
  - Otherwise 1 in FILL.
  - Otherwise, in RUN, (fifo_level < FIFO_DEPTH).
  - A same-cycle pop does NOT make room for a push when full.
- FILL state:
  - The k-th accepted record (k = 0..N_SLOT-1) is written to slot k. No FIFO push.
  - After the N_SLOT-th accept, state goes to RUN on the same edge.
- RUN state, on accept:
  - Score per slot: s = size*w_size + iq*w_iq + eq*w_eq, using the current slot contents and the weights sampled with the incoming record.
  - Score width: ATTR_W+WT_W+2 bits, unsigned, no overflow.
  - Winner: the slot with the maximum score (mode=0) or minimum score (mode=1). Ties go to the lowest slot index.
  - On that edge, {winner index, winner id} is written to the FIFO tail and the incoming record overwrites the winner slot.
  - The incoming record is not a candidate in its own evaluation.
- FIFO:
  - Synchronous and show-ahead: a push at edge t is visible on out_data with out_valid=1 in cycle t+1 if the FIFO was empty. Latency from accept to out_valid is one cycle.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - A pop when empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - out_data = 0 when empty.
- Flush (rst=0, flush=1):
  - Same effect as reset except weights are irrelevant: FIFO emptied, state goes to FILL, fill counter = 0.
  - in_valid in the same cycle is ignored and the record is dropped.
  - A pop in the same cycle is ignored.
- Priority: rst > flush > accept/pop.

Test Plan:
1. Basic selection. Fill with ids 1..5, sizes 10,20,30,40,50, iq=eq=0, w_size=1 (other weights 0), mode=0. Expect no output during fill. Then send id 6, size 0:
   - out_data = {3'd4, 5'd5} one cycle later.
   - Next record id 7, same weights: out_data = {3'd3, 5'd4}.
2. Tie-break. Fill with all slots iq=eq=size=7, weights 1/1/1. Each RUN record with identical attributes yields index 0 in both modes (sequence idx 0,0,0).
3. Min mode. Same pool as scenario 1, mode=1. Expect {0, id1}. The next record (size 5, id 8) overwrites slot 0, so the following min selects slot 0 again with id 8.
4. Backpressure. out_ready=0, push 16 RUN records:
   - fifo_level = 16 and in_ready = 0; a 17th in_valid is not accepted.
   - One pop gives fifo_level 15 and in_ready = 1 the next cycle.
   - Entries drain in push order.
5. Flush mid-RUN with 3 entries queued, and in_valid high in the same cycle:
   - Next cycle fifo_level = 0 and out_valid = 0; the record is dropped.
   - The following 5 accepts produce no output; the 6th produces output.
6. rst asserted for one cycle during simultaneous push and pop. All outputs return to reset values next cycle, and refill behaves as in scenario 1.
